ad9866_spi_reader: RTL

AD9866_SPI_READER -- requirements
Module: ad9866_spi_reader

---
 rtl/ad9866_spi_reader.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/ad9866_spi_reader.sv
// AD9866 SPI register reader: issues a 16-bit read frame and returns the 8-bit register value.
// Define AD9866_SPI_3WIRE_EN to read data back over the shared sdio pin instead of sdo.
module ad9866_spi_reader #(
  parameter int CLK_DIV = 4
) (
  input  logic       ad9866spiclk,
  input  logic       extreset,
  input  logic       start,
  input  logic [5:0] addr,
  output logic       busy,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic       ad9866_sclk,
  output logic       ad9866_sen_n,
  output logic       ad9866_sdio,
  output logic       ad9866_sdio_oe,
  input  logic       ad9866_sdio_i,
  input  logic       ad9866_sdo
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    INSTR,
    DATA,
    HOLD,
    DONE
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state_reg, state_next;
  logic [7:0] div_reg, div_next;
  logic [2:0] bit_reg, bit_next;
  logic [6:0] frame_reg, frame_next;
  logic [7:0] shift_reg, shift_next;
  logic       sclk_reg, sclk_next;
  logic       sen_n_reg, sen_n_next;
  logic       sdio_reg, sdio_next;
  logic       busy_reg, busy_next;
  logic       rvalid_reg, rvalid_next;
  logic [7:0] rdata_reg, rdata_next;

  logic       tick;
  logic [7:0] div_step;
  logic       din;

`ifdef AD9866_SPI_3WIRE_EN
  logic sdio_oe_reg, sdio_oe_next;
  logic unused_sdo;
  assign din            = ad9866_sdio_i;
  assign unused_sdo     = ad9866_sdo;
  assign ad9866_sdio_oe = sdio_oe_reg;
`else
  logic unused_sdio_i;
  assign din            = ad9866_sdo;
  assign unused_sdio_i  = ad9866_sdio_i;
  assign ad9866_sdio_oe = 1'b1;
`endif

  assign tick     = (div_reg == DIV_LAST);
  assign div_step = tick ? 8'd0 : div_reg + 8'd1;

  always_comb begin
    state_next   = state_reg;
    div_next     = div_reg;
    bit_next     = bit_reg;
    frame_next   = frame_reg;
    shift_next   = shift_reg;
    sclk_next    = sclk_reg;
    sen_n_next   = sen_n_reg;
    sdio_next    = sdio_reg;
    busy_next    = busy_reg;
    rvalid_next  = 1'b0;
    rdata_next   = rdata_reg;
`ifdef AD9866_SPI_3WIRE_EN
    sdio_oe_next = sdio_oe_reg;
`endif
    case (state_reg)
      IDLE: begin
        div_next = 8'd0;
        if (start) begin
          // frame_reg holds bits 14..8; bit 15 (read flag) goes straight to sdio
          frame_next = {addr, 1'b0};
          bit_next   = 3'd0;
          sclk_next  = 1'b0;
          busy_next  = 1'b1;
          sen_n_next = 1'b0;
          sdio_next  = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        div_next = div_step;
        if (tick) begin
          state_next = INSTR;
        end
      end
      INSTR: begin
        div_next = div_step;
        if (tick) begin
          if (!sclk_reg) begin
            sclk_next = 1'b1;
          end else begin
            sclk_next = 1'b0;
            if (bit_reg == 3'd7) begin
              bit_next   = 3'd0;
              sdio_next  = 1'b0;
              state_next = DATA;
`ifdef AD9866_SPI_3WIRE_EN
              sdio_oe_next = 1'b0;
`endif
            end else begin
              bit_next   = bit_reg + 3'd1;
              sdio_next  = frame_reg[6];
              frame_next = {frame_reg[5:0], 1'b0};
            end
          end
        end
      end
      DATA: begin
        div_next = div_step;
        if (tick) begin
          if (!sclk_reg) begin
            // sample on the same edge that raises sclk
            sclk_next  = 1'b1;
            shift_next = {shift_reg[6:0], din};
          end else begin
            sclk_next = 1'b0;
            if (bit_reg == 3'd7) begin
              bit_next   = 3'd0;
              state_next = HOLD;
`ifdef AD9866_SPI_3WIRE_EN
              sdio_oe_next = 1'b1;
`endif
            end else begin
              bit_next = bit_reg + 3'd1;
            end
          end
        end
      end
      HOLD: begin
        div_next = div_step;
        if (tick) begin
          sen_n_next  = 1'b1;
          sdio_next   = 1'b0;
          rdata_next  = shift_reg;
          rvalid_next = 1'b1;
          state_next  = DONE;
        end
      end
      DONE: begin
        div_next   = 8'd0;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge ad9866spiclk or posedge extreset) begin
    if (extreset) begin
      state_reg   <= IDLE;
      div_reg     <= 8'd0;
      bit_reg     <= 3'd0;
      frame_reg   <= 7'd0;
      shift_reg   <= 8'd0;
      sclk_reg    <= 1'b0;
      sen_n_reg   <= 1'b1;
      sdio_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= 8'h00;
`ifdef AD9866_SPI_3WIRE_EN
      sdio_oe_reg <= 1'b1;
`endif
    end else begin
      state_reg   <= state_next;
      div_reg     <= div_next;
      bit_reg     <= bit_next;
      frame_reg   <= frame_next;
      shift_reg   <= shift_next;
      sclk_reg    <= sclk_next;
      sen_n_reg   <= sen_n_next;
      sdio_reg    <= sdio_next;
      busy_reg    <= busy_next;
      rvalid_reg  <= rvalid_next;
      rdata_reg   <= rdata_next;
`ifdef AD9866_SPI_3WIRE_EN
      sdio_oe_reg <= sdio_oe_next;
`endif
    end
  end

  assign busy         = busy_reg;
  assign rdata        = rdata_reg;
  assign rvalid       = rvalid_reg;
  assign ad9866_sclk  = sclk_reg;
  assign ad9866_sen_n = sen_n_reg;
  assign ad9866_sdio  = sdio_reg;

endmodule
